// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, digit limit, controller states and digit helpers.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_DIGIT_W-1:0] BCD_RADIX_ADJ = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Result of one digit-cell evaluation.
  typedef struct packed {
    logic                   borrow;
    logic [BCD_DIGIT_W-1:0] diff;
  } digit_res_t;

  function automatic logic is_bcd_digit(input logic [BCD_DIGIT_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_subtractor.sv
// Combinational single-digit BCD subtractor: diff = a - b - borrow_in, ten's-complement on underflow.
module bcd_subtractor
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a_i,
  input  logic [BCD_DIGIT_W-1:0] b_i,
  input  logic                   borrow_i,
  output logic [BCD_DIGIT_W-1:0] diff_o,
  output logic                   borrow_o
);

  localparam int unsigned RAW_W = BCD_DIGIT_W + 1;

  logic [RAW_W-1:0] raw;
  digit_res_t       res;

  // Binary difference with one guard bit; the guard bit set means the digit underflowed.
  always_comb begin
    raw = {1'b0, a_i} - {1'b0, b_i} - RAW_W'(borrow_i);
    res = '0;
    if (raw[RAW_W-1]) begin
      res.diff   = raw[BCD_DIGIT_W-1:0] + BCD_RADIX_ADJ;
      res.borrow = 1'b1;
    end else begin
      res.diff   = raw[BCD_DIGIT_W-1:0];
      res.borrow = 1'b0;
    end
  end

  assign diff_o   = res.diff;
  assign borrow_o = res.borrow;

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: one shared digit cell, LSD first, borrow carried between digits.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] a_i,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] b_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [BCD_DIGIT_W*DIGITS-1:0] diff_o,
  output logic                          borrow_o,
  output logic                          err_o
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef logic [DIGITS-1:0][BCD_DIGIT_W-1:0] digits_t;

  state_e                 state;
  digits_t                a_q;
  digits_t                b_q;
  digits_t                diff_q;
  digits_t                a_in;
  digits_t                b_in;
  logic [IDX_W-1:0]       idx;
  logic                   borrow_q;
  logic                   operand_err_c;
  logic [BCD_DIGIT_W-1:0] cell_diff;
  logic                   cell_borrow;

  assign a_in   = a_i;
  assign b_in   = b_i;
  assign diff_o = diff_q;

  // Any non-decimal digit in either incoming operand flags the operation.
  always_comb begin
    operand_err_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!is_bcd_digit(a_in[i]) || !is_bcd_digit(b_in[i])) begin
        operand_err_c = 1'b1;
      end
    end
  end

  bcd_subtractor u_cell (
    .a_i      (a_q[idx]),
    .b_i      (b_q[idx]),
    .borrow_i (borrow_q),
    .diff_o   (cell_diff),
    .borrow_o (cell_borrow)
  );

  // Controller: latch on start, walk the digits, then present the result for one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      diff_q   <= '0;
      borrow_o <= 1'b0;
      err_o    <= 1'b0;
      idx      <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          busy_o <= 1'b0;
          if (start_i) begin
            a_q      <= a_in;
            b_q      <= b_in;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            borrow_o <= 1'b0;
            err_o    <= operand_err_c;
            idx      <= '0;
            busy_o   <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          busy_o      <= 1'b1;
          diff_q[idx] <= cell_diff;
          borrow_q    <= cell_borrow;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          busy_o   <= 1'b1;
          done_o   <= 1'b1;
          borrow_o <= borrow_q;
          state    <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
